mode_sequencer: RTL and testbench

- Top-level mode/edit controller for the digital clock. Turns button pulses into the 4-bit `state` bus that sequences the LED driver, alarm, timer and time-set datapath.
- Cycles display modes, steps through edit fields, and produces one-cycle commit/abort strobes.
- Returns to the parent display after an inactivity timeout.
- Generates the per-digit blank mask that makes the field under edit blink.

---
 rtl/mode_sequencer_if.sv | 25 ++
 rtl/mode_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_mode_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mode_sequencer_if.sv
// Button/tick inputs and mode/blink outputs of the clock's mode sequencer.
// master drives the pulses and observes the mode; slave is the sequencer itself.
interface mode_sequencer_if;
    logic       tick_sec;
    logic       tick_blink;
    logic       mode_btn;
    logic       edit_btn;
    logic       up_btn;
    logic       down_btn;
    logic [3:0] state;
    logic       edit_active;
    logic       commit;
    logic       abort;
    logic [7:0] blank_mask;

    modport master (
        output tick_sec, tick_blink, mode_btn, edit_btn, up_btn, down_btn,
        input  state, edit_active, commit, abort, blank_mask
    );

    modport slave (
        input  tick_sec, tick_blink, mode_btn, edit_btn, up_btn, down_btn,
        output state, edit_active, commit, abort, blank_mask
    );
endinterface

// File: rtl/mode_sequencer.sv
// Display-mode / edit-field controller for the digital clock with timeout and field blink.
// Optional macro EDIT_MODE_ABORT_EN: mode_btn inside an edit aborts back to the parent display.
module mode_sequencer #(
    parameter int TIMEOUT_S = 30
) (
    input  logic            clk,
    input  logic            rst,
    mode_sequencer_if.slave bus
);

    typedef enum logic [3:0] {
        TIME_DISP         = 4'd0,
        DATE_DISP         = 4'd1,
        TIME_EDIT_SECOND  = 4'd2,
        TIME_EDIT_MINUTE  = 4'd3,
        TIME_EDIT_HOUR    = 4'd4,
        TIME_EDIT_DAY     = 4'd5,
        TIME_EDIT_MONTH   = 4'd6,
        TIME_EDIT_YEAR    = 4'd7,
        ALARM_DISP        = 4'd8,
        ALARM_EDIT_SECOND = 4'd9,
        ALARM_EDIT_MINUTE = 4'd10,
        ALARM_EDIT_HOUR   = 4'd11,
        TIMER_DISP        = 4'd12,
        TIMER_EDIT_SECOND = 4'd13,
        TIMER_EDIT_MINUTE = 4'd14,
        TIMER_EDIT_HOUR   = 4'd15
    } state_e;

    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT_S);

    function automatic logic is_edit(input state_e s);
        return !(s inside {TIME_DISP, DATE_DISP, ALARM_DISP, TIMER_DISP});
    endfunction

    function automatic logic is_last_field(input state_e s);
        return s inside {TIME_EDIT_HOUR, TIME_EDIT_YEAR, ALARM_EDIT_HOUR, TIMER_EDIT_HOUR};
    endfunction

    function automatic state_e parent_of(input state_e s);
        state_e r;
        case (s)
            TIME_EDIT_SECOND, TIME_EDIT_MINUTE, TIME_EDIT_HOUR:    r = TIME_DISP;
            TIME_EDIT_DAY, TIME_EDIT_MONTH, TIME_EDIT_YEAR:        r = DATE_DISP;
            ALARM_EDIT_SECOND, ALARM_EDIT_MINUTE, ALARM_EDIT_HOUR: r = ALARM_DISP;
            TIMER_EDIT_SECOND, TIMER_EDIT_MINUTE, TIMER_EDIT_HOUR: r = TIMER_DISP;
            default:                                               r = s;
        endcase
        return r;
    endfunction

    function automatic state_e next_mode(input state_e s);
        state_e r;
        case (s)
            TIME_DISP:  r = DATE_DISP;
            DATE_DISP:  r = ALARM_DISP;
            ALARM_DISP: r = TIMER_DISP;
            default:    r = TIME_DISP;
        endcase
        return r;
    endfunction

    function automatic state_e first_field(input state_e s);
        state_e r;
        case (s)
            TIME_DISP:  r = TIME_EDIT_SECOND;
            DATE_DISP:  r = TIME_EDIT_DAY;
            ALARM_DISP: r = ALARM_EDIT_SECOND;
            default:    r = TIMER_EDIT_SECOND;
        endcase
        return r;
    endfunction

    // Last fields map to their parent; callers check is_last_field first.
    function automatic state_e next_field(input state_e s);
        state_e r;
        case (s)
            TIME_EDIT_SECOND:  r = TIME_EDIT_MINUTE;
            TIME_EDIT_MINUTE:  r = TIME_EDIT_HOUR;
            TIME_EDIT_DAY:     r = TIME_EDIT_MONTH;
            TIME_EDIT_MONTH:   r = TIME_EDIT_YEAR;
            ALARM_EDIT_SECOND: r = ALARM_EDIT_MINUTE;
            ALARM_EDIT_MINUTE: r = ALARM_EDIT_HOUR;
            TIMER_EDIT_SECOND: r = TIMER_EDIT_MINUTE;
            TIMER_EDIT_MINUTE: r = TIMER_EDIT_HOUR;
            default:           r = parent_of(s);
        endcase
        return r;
    endfunction

    function automatic logic [7:0] field_mask(input state_e s);
        logic [7:0] m;
        case (s)
            TIME_EDIT_SECOND, TIMER_EDIT_SECOND: m = 8'h03;
            TIME_EDIT_MINUTE, TIMER_EDIT_MINUTE: m = 8'h18;
            TIME_EDIT_HOUR, TIMER_EDIT_HOUR:     m = 8'hC0;
            TIME_EDIT_DAY:                       m = 8'h03;
            TIME_EDIT_MONTH:                     m = 8'h0C;
            TIME_EDIT_YEAR:                      m = 8'hF0;
            ALARM_EDIT_SECOND:                   m = 8'h03;
            ALARM_EDIT_MINUTE:                   m = 8'h0C;
            ALARM_EDIT_HOUR:                     m = 8'h30;
            default:                             m = 8'h00;
        endcase
        return m;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       phase_q, phase_d;
    logic       commit_q, commit_d;
    logic       abort_q, abort_d;
    logic       edit_active_q, edit_active_d;
    logic [7:0] blank_mask_q, blank_mask_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        commit_d = 1'b0;
        abort_d  = 1'b0;

        if (!is_edit(state_q)) begin
            cnt_d   = 8'd0;
            phase_d = 1'b0;
            if (bus.edit_btn) begin
                state_d = first_field(state_q);
            end else if (bus.mode_btn) begin
                state_d = next_mode(state_q);
            end
        end else if (bus.edit_btn) begin
            cnt_d    = 8'd0;
            phase_d  = 1'b0;
            state_d  = next_field(state_q);
            commit_d = is_last_field(state_q);
        end
`ifdef EDIT_MODE_ABORT_EN
        else if (bus.mode_btn) begin
            cnt_d   = 8'd0;
            phase_d = 1'b0;
            state_d = parent_of(state_q);
            abort_d = 1'b1;
        end
`endif
        else if (bus.up_btn || bus.down_btn) begin
            cnt_d   = 8'd0;
            phase_d = 1'b0;
        end else if (bus.tick_sec && (cnt_q == TIMEOUT_L)) begin
            // Expiry needs one further tick after the count reaches the limit.
            cnt_d   = 8'd0;
            phase_d = 1'b0;
            state_d = parent_of(state_q);
            abort_d = 1'b1;
        end else begin
            if (bus.tick_sec) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (bus.tick_blink) begin
                phase_d = ~phase_q;
            end
        end

        edit_active_d = is_edit(state_d);
        blank_mask_d  = field_mask(state_d) & {8{phase_d}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= TIME_DISP;
            cnt_q         <= 8'd0;
            phase_q       <= 1'b0;
            commit_q      <= 1'b0;
            abort_q       <= 1'b0;
            edit_active_q <= 1'b0;
            blank_mask_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            commit_q      <= commit_d;
            abort_q       <= abort_d;
            edit_active_q <= edit_active_d;
            blank_mask_q  <= blank_mask_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.edit_active = edit_active_q;
    assign bus.commit      = commit_q;
    assign bus.abort       = abort_q;
    assign bus.blank_mask  = blank_mask_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed scenarios with literal expectations, then random
// button/tick traffic checked every cycle against a table-driven model of the mode rules.
module tb_mode_sequencer;

    localparam int TO = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mode_sequencer_if bus_if ();

    mode_sequencer #(.TIMEOUT_S(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model tables indexed by state code.
    int  parent_t [16] = '{0, 1, 0, 0, 0, 1, 1, 1, 8, 8, 8, 8, 12, 12, 12, 12};
    int  mode_t   [16] = '{1, 8, 0, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0};
    int  first_t  [16] = '{2, 5, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 13, 0, 0, 0};
    byte mask_t   [16] = '{8'h00, 8'h00, 8'h03, 8'h18, 8'hC0, 8'h03, 8'h0C, 8'hF0,
                           8'h00, 8'h03, 8'h0C, 8'h30, 8'h00, 8'h03, 8'h18, 8'hC0};

    int m_state = 0;
    int m_cnt   = 0;
    bit m_phase = 0;
    bit m_commit = 0;
    bit m_abort  = 0;
    bit cmp_en   = 0;

    function automatic bit editing(input int s);
        return !(s == 0 || s == 1 || s == 8 || s == 12);
    endfunction

    function automatic bit last_field(input int s);
        return (s == 4 || s == 7 || s == 11 || s == 15);
    endfunction

    always @(posedge clk) begin
        m_commit = 0;
        m_abort  = 0;
        if (rst) begin
            m_state = 0; m_cnt = 0; m_phase = 0;
        end else if (!editing(m_state)) begin
            if (bus_if.edit_btn)      m_state = first_t[m_state];
            else if (bus_if.mode_btn) m_state = mode_t[m_state];
            m_cnt = 0; m_phase = 0;
        end else if (bus_if.edit_btn) begin
            if (last_field(m_state)) begin
                m_state = parent_t[m_state]; m_commit = 1;
            end else begin
                m_state = m_state + 1;
            end
            m_cnt = 0; m_phase = 0;
        end else if (bus_if.up_btn || bus_if.down_btn) begin
            m_cnt = 0; m_phase = 0;
        end else if (bus_if.tick_sec && m_cnt == TO) begin
            m_state = parent_t[m_state]; m_abort = 1; m_cnt = 0; m_phase = 0;
        end else begin
            if (bus_if.tick_sec)   m_cnt = m_cnt + 1;
            if (bus_if.tick_blink) m_phase = !m_phase;
        end
        #1;
        if (cmp_en) begin
            chk("model_state", 32'(bus_if.state), 32'(m_state));
            chk("model_edit_active", 32'(bus_if.edit_active), 32'(editing(m_state)));
            chk("model_commit", 32'(bus_if.commit), 32'(m_commit));
            chk("model_abort", 32'(bus_if.abort), 32'(m_abort));
            chk("model_blank_mask", 32'(bus_if.blank_mask), 32'(m_phase ? mask_t[m_state] : 8'h00));
        end
    end

    task automatic clear_inputs();
        bus_if.mode_btn = 0; bus_if.edit_btn = 0; bus_if.up_btn = 0;
        bus_if.down_btn = 0; bus_if.tick_sec = 0; bus_if.tick_blink = 0;
    endtask

    // One clock with the given pulses; outputs are then valid for checking.
    task automatic step(input bit md, input bit ed, input bit up, input bit dn,
                        input bit ts, input bit tb);
        bus_if.mode_btn = md; bus_if.edit_btn = ed; bus_if.up_btn = up;
        bus_if.down_btn = dn; bus_if.tick_sec = ts; bus_if.tick_blink = tb;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic expect_out(input string nm, input int st, input bit cm, input bit ab,
                              input int bm);
        chk({nm, "_state"}, 32'(bus_if.state), 32'(st));
        chk({nm, "_commit"}, 32'(bus_if.commit), 32'(cm));
        chk({nm, "_abort"}, 32'(bus_if.abort), 32'(ab));
        chk({nm, "_blank"}, 32'(bus_if.blank_mask), 32'(bm));
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        cmp_en = 1;
        expect_out("reset", 0, 0, 0, 0);
        chk("reset_edit_active", 32'(bus_if.edit_active), 32'd0);

        // Display mode cycle.
        step(1, 0, 0, 0, 0, 0); expect_out("mode1", 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); expect_out("mode2", 8, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); expect_out("mode3", 12, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); expect_out("mode4", 0, 0, 0, 0);

        // Time edit walk with commit.
        step(0, 1, 0, 0, 0, 0); expect_out("edit1", 2, 0, 0, 0);
        chk("edit1_edit_active", 32'(bus_if.edit_active), 32'd1);
        step(0, 1, 0, 0, 0, 0); expect_out("edit2", 3, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0); expect_out("edit3", 4, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0); expect_out("edit4", 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0); expect_out("post_commit", 0, 0, 0, 0);

        // Blink in the seconds field, then up_btn clears the phase.
        step(0, 1, 0, 0, 0, 0); expect_out("blk_enter", 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1); expect_out("blk1", 2, 0, 0, 8'h03);
        step(0, 0, 0, 0, 0, 1); expect_out("blk2", 2, 0, 0, 8'h00);
        step(0, 0, 0, 0, 0, 1); expect_out("blk3", 2, 0, 0, 8'h03);
        step(0, 0, 1, 0, 0, 0); expect_out("blk_up", 2, 0, 0, 8'h00);
        repeat (3) step(0, 1, 0, 0, 0, 0);
        expect_out("blk_exit", 0, 1, 0, 0);

        // Timeout in ALARM_EDIT_MINUTE.
        step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
        expect_out("to_enter", 10, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        expect_out("to_three", 10, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0); expect_out("to_expire", 8, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0); expect_out("to_after", 8, 0, 0, 0);

        // Button coincident with the expiring tick keeps the edit alive.
        step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 1, 0); expect_out("to_saved", 10, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0, 1, 0);
        expect_out("to_restart", 10, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0); expect_out("to_expire2", 8, 0, 1, 0);

        // edit_btn beats mode_btn; reset mid-edit.
        step(1, 0, 0, 0, 0, 0); expect_out("tmr_disp", 12, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0); expect_out("tmr_both", 13, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1); expect_out("tmr_min", 14, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1); expect_out("tmr_blink", 14, 0, 0, 8'h18);
        rst = 1;
        @(negedge clk);
        rst = 0;
        expect_out("rst_mid", 0, 0, 0, 0);
        chk("rst_mid_edit_active", 32'(bus_if.edit_active), 32'd0);

        // mode_btn ignored in TIME_EDIT_MONTH.
        step(1, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
        expect_out("month", 6, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0); expect_out("month_mode", 6, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0); expect_out("month_idle", 6, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bus_if.mode_btn   = ($urandom_range(0, 7) == 0);
            bus_if.edit_btn   = ($urandom_range(0, 9) == 0);
            bus_if.up_btn     = ($urandom_range(0, 15) == 0);
            bus_if.down_btn   = ($urandom_range(0, 15) == 0);
            bus_if.tick_sec   = ($urandom_range(0, 2) == 0);
            bus_if.tick_blink = ($urandom_range(0, 2) == 0);
            rst               = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        clear_inputs();
        rst = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
